// File: rtl/bp_be_fe_cmd_issuer.sv
// ---------------------------------------------------------------------------
// bp_be_fe_cmd_issuer
//
// Backend-side peer of the front end.
//   * Forwards fetch-queue entries to the issue stage (combinational path).
//   * Buffers redirect / fence / attaboy requests from execute in a small
//     FIFO and presents the head to the FE as a command.
//   * After an accepted redirect or fence, drops stale fetch-queue entries
//     until a fetch whose PC equals the new target arrives.
//
// Optional feature: define BP_BE_FE_CMD_STATS_EN to add three 32-bit
// saturating counters (redirect_cnt_o, squash_cnt_o, attaboy_drop_cnt_o).
//
// Fetch-queue entry layout (MSB..LSB):
//   msg_type[1:0] (0 = fetch, 1 = exception) | pc[vaddr] | instr[31:0] | meta[bmf]
// FE command layout (MSB..LSB):
//   opcode[2:0] | operands, where operands hold, zero-extended from bit 0,
//   { pc[vaddr], subopcode[2:0], branch_metadata_fwd[bmf] }.
//   Opcodes: 0 state_reset, 1 pc_redirection, 2 icache_fence, 3 attaboy.
//   Subopcode 1 = branch_mispredict (only used by redirects, else 0).
//
// Ports:
//   clk_i, reset_n_i               clock, async active-low reset
//   fe_queue_i/_v_i/_ready_o       entry from FE
//   issue_o/_v_o, issue_ready_i    entry to the issue stage
//   redirect_*, fence_*, attaboy_* requests from execute
//   fe_cmd_o/_v_o, fe_cmd_ready_i  command to FE
//   squashing_o                    high while stale entries are being dropped
// ---------------------------------------------------------------------------
module bp_be_fe_cmd_issuer #(
  parameter int vaddr_width_p    = 39,
  parameter int paddr_width_p    = 40,
  parameter int asid_width_p     = 10,
  parameter int btb_indx_width_p = 9,
  parameter int bht_indx_width_p = 9,
  parameter int ras_addr_width_p = 2,
  parameter int cmd_fifo_els_p   = 4,
  localparam int bmf_width_lp       = btb_indx_width_p + bht_indx_width_p + ras_addr_width_p,
  localparam int fe_queue_width_lp  = 2 + vaddr_width_p + 32 + bmf_width_lp,
  localparam int redir_ops_width_lp = vaddr_width_p + 3 + bmf_width_lp,
  localparam int xlate_ops_width_lp = paddr_width_p + asid_width_p,
  localparam int fe_cmd_ops_width_lp = (redir_ops_width_lp > xlate_ops_width_lp)
                                       ? redir_ops_width_lp : xlate_ops_width_lp,
  localparam int fe_cmd_width_lp    = 3 + fe_cmd_ops_width_lp
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic [fe_queue_width_lp-1:0]  fe_queue_i,
  input  logic                          fe_queue_v_i,
  output logic                          fe_queue_ready_o,
  output logic [fe_queue_width_lp-1:0]  issue_o,
  output logic                          issue_v_o,
  input  logic                          issue_ready_i,
  input  logic                          redirect_v_i,
  input  logic [vaddr_width_p-1:0]      redirect_pc_i,
  input  logic [bmf_width_lp-1:0]       redirect_meta_i,
  output logic                          redirect_ready_o,
  input  logic                          fence_v_i,
  input  logic [vaddr_width_p-1:0]      fence_pc_i,
  output logic                          fence_ready_o,
  input  logic                          attaboy_v_i,
  input  logic [vaddr_width_p-1:0]      attaboy_pc_i,
  input  logic [bmf_width_lp-1:0]       attaboy_meta_i,
  output logic [fe_cmd_width_lp-1:0]    fe_cmd_o,
  output logic                          fe_cmd_v_o,
  input  logic                          fe_cmd_ready_i,
`ifdef BP_BE_FE_CMD_STATS_EN
  output logic [31:0]                   redirect_cnt_o,
  output logic [31:0]                   squash_cnt_o,
  output logic [31:0]                   attaboy_drop_cnt_o,
`endif
  output logic                          squashing_o
);

  typedef enum logic [2:0] {
    e_op_state_reset    = 3'd0,
    e_op_pc_redirection = 3'd1,
    e_op_icache_fence   = 3'd2,
    e_op_attaboy        = 3'd3
  } fe_cmd_opcode_e;

  typedef enum logic [0:0] {
    e_run    = 1'b0,
    e_squash = 1'b1
  } state_e;

  localparam logic [2:0] SUBOP_BRANCH_MISPREDICT = 3'd1;
  localparam logic [1:0] MSG_FETCH               = 2'd0;
  localparam int PTR_W = $clog2(cmd_fifo_els_p);
  localparam int CNT_W = $clog2(cmd_fifo_els_p + 1);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(cmd_fifo_els_p - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  logic [fe_cmd_width_lp-1:0] r_mem [cmd_fifo_els_p];
  logic [PTR_W-1:0]           r_rd_ptr, r_wr_ptr;
  logic [CNT_W-1:0]           r_cnt;
  state_e                     r_state, w_state_n;
  logic [vaddr_width_p-1:0]   r_target_pc, w_target_n;

  logic w_full, w_empty, w_enq, w_deq;
  logic w_redirect_acc, w_fence_acc, w_attaboy_acc, w_new_tgt;
  logic w_issue_v, w_fe_ready, w_match, w_drop;
  logic [fe_cmd_width_lp-1:0] w_enq_cmd;
  logic [1:0]                 w_fe_type;
  logic [vaddr_width_p-1:0]   w_fe_pc;

  assign w_full  = (r_cnt == CNT_W'(cmd_fifo_els_p));
  assign w_empty = (r_cnt == CNT_W'(0));

  // Request arbitration: redirect > fence > attaboy; gated off while in reset.
  assign w_redirect_acc = reset_n_i & redirect_v_i & ~w_full;
  assign w_fence_acc    = reset_n_i & fence_v_i & ~w_full & ~redirect_v_i;
  assign w_attaboy_acc  = reset_n_i & attaboy_v_i & ~w_full & ~redirect_v_i & ~fence_v_i;
  assign w_new_tgt      = w_redirect_acc | w_fence_acc;
  assign w_enq          = w_new_tgt | w_attaboy_acc;
  assign w_deq          = ~w_empty & fe_cmd_ready_i;

  assign w_fe_type = fe_queue_i[fe_queue_width_lp-1 -: 2];
  assign w_fe_pc   = fe_queue_i[fe_queue_width_lp-3 -: vaddr_width_p];

  // Build the command word for whichever request wins this cycle.
  always_comb begin
    w_enq_cmd = '0;
    if (w_redirect_acc) begin
      w_enq_cmd = {e_op_pc_redirection,
                   fe_cmd_ops_width_lp'({redirect_pc_i, SUBOP_BRANCH_MISPREDICT, redirect_meta_i})};
    end else if (w_fence_acc) begin
      w_enq_cmd = {e_op_icache_fence,
                   fe_cmd_ops_width_lp'({fence_pc_i, 3'b000, {bmf_width_lp{1'b0}}})};
    end else if (w_attaboy_acc) begin
      w_enq_cmd = {e_op_attaboy,
                   fe_cmd_ops_width_lp'({attaboy_pc_i, 3'b000, attaboy_meta_i})};
    end else begin
      w_enq_cmd = '0;
    end
  end

  // Command FIFO storage, pointers and occupancy.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
      for (int i = 0; i < cmd_fifo_els_p; i++) r_mem[i] <= '0;
    end else begin
      if (w_enq) begin
        r_mem[r_wr_ptr] <= w_enq_cmd;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_deq) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_enq, w_deq})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Squash FSM next-state and fetch-queue handshake.
  always_comb begin
    w_state_n  = r_state;
    w_target_n = r_target_pc;
    w_issue_v  = 1'b0;
    w_fe_ready = 1'b0;
    w_match    = 1'b0;
    w_drop     = 1'b0;
    case (r_state)
      e_run: begin
        w_issue_v  = fe_queue_v_i;
        w_fe_ready = issue_ready_i;
      end
      e_squash: begin
        // A newly accepted target this cycle overrides a match on the old one.
        w_match = fe_queue_v_i & (w_fe_type == MSG_FETCH) &
                  (w_fe_pc == r_target_pc) & ~w_new_tgt;
        if (w_match) begin
          w_issue_v  = 1'b1;
          w_fe_ready = issue_ready_i;
          if (issue_ready_i) w_state_n = e_run;
          else               w_state_n = e_squash;
        end else begin
          w_issue_v  = 1'b0;
          w_fe_ready = 1'b1;
          w_drop     = fe_queue_v_i;
        end
      end
      default: w_state_n = e_run;
    endcase
    if (w_new_tgt) begin
      w_state_n  = e_squash;
      w_target_n = w_redirect_acc ? redirect_pc_i : fence_pc_i;
    end else begin
      w_target_n = w_target_n;
    end
  end

  // FSM state and squash target registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state     <= e_run;
      r_target_pc <= '0;
    end else begin
      r_state     <= w_state_n;
      r_target_pc <= w_target_n;
    end
  end

  // Handshakes are forced low while reset is asserted, not just after the next edge.
  assign fe_queue_ready_o = reset_n_i & w_fe_ready;
  assign issue_v_o        = reset_n_i & w_issue_v;
  assign issue_o          = reset_n_i ? fe_queue_i : '0;
  assign redirect_ready_o = reset_n_i & ~w_full;
  assign fence_ready_o    = reset_n_i & ~w_full & ~redirect_v_i;
  assign fe_cmd_v_o       = ~w_empty;
  assign fe_cmd_o         = w_empty ? '0 : r_mem[r_rd_ptr];
  assign squashing_o      = (r_state == e_squash);

`ifdef BP_BE_FE_CMD_STATS_EN
  logic [31:0] r_redirect_cnt, r_squash_cnt, r_att_drop_cnt;

  // Saturating event counters.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_redirect_cnt <= 32'd0;
      r_squash_cnt   <= 32'd0;
      r_att_drop_cnt <= 32'd0;
    end else begin
      if (w_redirect_acc && (r_redirect_cnt != 32'hFFFF_FFFF))
        r_redirect_cnt <= r_redirect_cnt + 32'd1;
      if (w_drop && (r_squash_cnt != 32'hFFFF_FFFF))
        r_squash_cnt <= r_squash_cnt + 32'd1;
      if (attaboy_v_i && !w_attaboy_acc && (r_att_drop_cnt != 32'hFFFF_FFFF))
        r_att_drop_cnt <= r_att_drop_cnt + 32'd1;
    end
  end

  assign redirect_cnt_o     = r_redirect_cnt;
  assign squash_cnt_o       = r_squash_cnt;
  assign attaboy_drop_cnt_o = r_att_drop_cnt;
`endif

endmodule

// File: tb/tb_bp_be_fe_cmd_issuer.sv
module tb_bp_be_fe_cmd_issuer;
  localparam int V   = 32;
  localparam int PA  = 34;
  localparam int AS  = 4;
  localparam int BTB = 4;
  localparam int BHT = 3;
  localparam int RAS = 1;
  localparam int N   = 4;
  localparam int BMF = BTB + BHT + RAS;
  localparam int QW  = 2 + V + 32 + BMF;
  localparam int OPW = ((V + 3 + BMF) > (PA + AS)) ? (V + 3 + BMF) : (PA + AS);
  localparam int CW  = 3 + OPW;

  localparam logic [2:0] OP_REDIR = 3'd1;
  localparam logic [2:0] OP_FENCE = 3'd2;
  localparam logic [2:0] OP_ATTA  = 3'd3;
  localparam logic [2:0] SUB_MISP = 3'd1;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          reset_n_i;
  logic [QW-1:0] fe_queue_i, issue_o;
  logic          fe_queue_v_i, fe_queue_ready_o, issue_v_o, issue_ready_i;
  logic          redirect_v_i, redirect_ready_o, fence_v_i, fence_ready_o, attaboy_v_i;
  logic [V-1:0]  redirect_pc_i, fence_pc_i, attaboy_pc_i;
  logic [BMF-1:0] redirect_meta_i, attaboy_meta_i;
  logic [CW-1:0] fe_cmd_o;
  logic          fe_cmd_v_o, fe_cmd_ready_i, squashing_o;
`ifdef BP_BE_FE_CMD_STATS_EN
  logic [31:0]   redirect_cnt_o, squash_cnt_o, attaboy_drop_cnt_o;
`endif

  bp_be_fe_cmd_issuer #(
    .vaddr_width_p(V), .paddr_width_p(PA), .asid_width_p(AS),
    .btb_indx_width_p(BTB), .bht_indx_width_p(BHT), .ras_addr_width_p(RAS),
    .cmd_fifo_els_p(N)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .fe_queue_i(fe_queue_i), .fe_queue_v_i(fe_queue_v_i), .fe_queue_ready_o(fe_queue_ready_o),
    .issue_o(issue_o), .issue_v_o(issue_v_o), .issue_ready_i(issue_ready_i),
    .redirect_v_i(redirect_v_i), .redirect_pc_i(redirect_pc_i), .redirect_meta_i(redirect_meta_i),
    .redirect_ready_o(redirect_ready_o),
    .fence_v_i(fence_v_i), .fence_pc_i(fence_pc_i), .fence_ready_o(fence_ready_o),
    .attaboy_v_i(attaboy_v_i), .attaboy_pc_i(attaboy_pc_i), .attaboy_meta_i(attaboy_meta_i),
    .fe_cmd_o(fe_cmd_o), .fe_cmd_v_o(fe_cmd_v_o), .fe_cmd_ready_i(fe_cmd_ready_i),
`ifdef BP_BE_FE_CMD_STATS_EN
    .redirect_cnt_o(redirect_cnt_o), .squash_cnt_o(squash_cnt_o),
    .attaboy_drop_cnt_o(attaboy_drop_cnt_o),
`endif
    .squashing_o(squashing_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [CW-1:0] exp_cmd_q [$];
  logic [QW-1:0] exp_iss_q [$];

  // Reference model state: FIFO occupancy, squash flag and target.
  int           m_occ = 0;
  bit           m_squash = 1'b0;
  logic [V-1:0] m_target = '0;
  int           m_att_drop = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] mk_cmd(input logic [2:0] op, input logic [2:0] sub,
                                           input logic [V-1:0] pc, input logic [BMF-1:0] meta);
    logic [OPW-1:0] ops;
    ops = '0;
    ops[V+3+BMF-1:0] = {pc, sub, meta};
    return {op, ops};
  endfunction

  function automatic logic [QW-1:0] mk_entry(input logic [1:0] t, input logic [V-1:0] pc);
    return {t, pc, 32'($urandom), BMF'($urandom)};
  endfunction

  function automatic logic [V-1:0] pick_pc();
    logic [V-1:0] pool [4];
    pool = '{32'h0000_0100, 32'h0000_0200, 32'h0000_0300, 32'h8000_0040};
    if ($urandom_range(0, 4) == 0) return V'($urandom);
    return pool[$urandom_range(0, 3)];
  endfunction

  // Command monitor: pops an expectation whenever the FE takes a command.
  always @(negedge clk_i) begin
    if (reset_n_i && fe_cmd_v_o && fe_cmd_ready_i) begin
      if (exp_cmd_q.size() == 0) check("fe_cmd_unexpected", 128'(fe_cmd_o), 128'(0));
      else check("fe_cmd", 128'(fe_cmd_o), 128'(exp_cmd_q.pop_front()));
    end
  end

  // Issue monitor: pops an expectation whenever the issue stage takes an entry.
  always @(negedge clk_i) begin
    if (reset_n_i && issue_v_o && issue_ready_i) begin
      if (exp_iss_q.size() == 0) check("issue_unexpected", 128'(issue_o), 128'(0));
      else check("issue", 128'(issue_o), 128'(exp_iss_q.pop_front()));
    end
  end

  task automatic idle();
    fe_queue_i = '0; fe_queue_v_i = 1'b0; issue_ready_i = 1'b1;
    redirect_v_i = 1'b0; redirect_pc_i = '0; redirect_meta_i = '0;
    fence_v_i = 1'b0; fence_pc_i = '0;
    attaboy_v_i = 1'b0; attaboy_pc_i = '0; attaboy_meta_i = '0;
    fe_cmd_ready_i = 1'b1;
  endtask

  // One clock: predict this cycle's handshakes from the current inputs, then advance.
  task automatic step();
    bit full, empty, racc, facc, aacc, newt, fwd, qrdy, match, deq;
    #1;
    full  = (m_occ == N);
    empty = (m_occ == 0);
    racc  = redirect_v_i && !full;
    facc  = fence_v_i && !full && !redirect_v_i;
    aacc  = attaboy_v_i && !full && !redirect_v_i && !fence_v_i;
    newt  = racc || facc;
    match = 1'b0;
    if (!m_squash) begin
      fwd  = fe_queue_v_i;
      qrdy = issue_ready_i;
    end else begin
      match = fe_queue_v_i && (fe_queue_i[QW-1 -: 2] == 2'd0) &&
              (fe_queue_i[QW-3 -: V] == m_target) && !newt;
      fwd  = match;
      qrdy = match ? issue_ready_i : 1'b1;
    end
    check("redirect_ready", 128'(redirect_ready_o), 128'(!full));
    check("fence_ready", 128'(fence_ready_o), 128'(!full && !redirect_v_i));
    check("fe_cmd_v", 128'(fe_cmd_v_o), 128'(!empty));
    check("squashing", 128'(squashing_o), 128'(m_squash));
    check("issue_v", 128'(issue_v_o), 128'(fwd));
    check("fe_queue_ready", 128'(fe_queue_ready_o), 128'(qrdy));
    if (fwd && issue_ready_i) exp_iss_q.push_back(fe_queue_i);
    if (racc) exp_cmd_q.push_back(mk_cmd(OP_REDIR, SUB_MISP, redirect_pc_i, redirect_meta_i));
    if (facc) exp_cmd_q.push_back(mk_cmd(OP_FENCE, 3'd0, fence_pc_i, BMF'(0)));
    if (aacc) exp_cmd_q.push_back(mk_cmd(OP_ATTA, 3'd0, attaboy_pc_i, attaboy_meta_i));
    if (attaboy_v_i && !aacc) m_att_drop++;
    deq = !empty && fe_cmd_ready_i;
    @(posedge clk_i);
    m_occ = m_occ + int'(racc || facc || aacc) - int'(deq);
    if (newt) begin
      m_squash = 1'b1;
      m_target = racc ? redirect_pc_i : fence_pc_i;
    end else if (m_squash && match && issue_ready_i) begin
      m_squash = 1'b0;
    end
    #1;
  endtask

  task automatic fetch(input logic [1:0] t, input logic [V-1:0] pc);
    fe_queue_v_i = 1'b1;
    fe_queue_i   = mk_entry(t, pc);
    step();
    fe_queue_v_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fe_cmd_v"}, 128'(fe_cmd_v_o), 128'(0));
    check({tag, "_issue_v"}, 128'(issue_v_o), 128'(0));
    check({tag, "_fe_queue_ready"}, 128'(fe_queue_ready_o), 128'(0));
    check({tag, "_squashing"}, 128'(squashing_o), 128'(0));
    check({tag, "_redirect_ready"}, 128'(redirect_ready_o), 128'(0));
    check({tag, "_fence_ready"}, 128'(fence_ready_o), 128'(0));
  endtask

  initial begin
    idle();
    reset_n_i = 1'b0;
    fe_queue_v_i = 1'b1;
    redirect_v_i = 1'b1;
    #12;
    check_reset_outputs("reset");
    @(posedge clk_i); #1;
    reset_n_i = 1'b1;
    idle();

    // Redirect from an empty FIFO.
    redirect_v_i = 1'b1; redirect_pc_i = 32'h8000_0040; redirect_meta_i = BMF'($urandom);
    step();
    idle();
    step();

    // Stale fetches and an exception are dropped until the target fetch arrives.
    fetch(2'd0, 32'h8000_0010);
    fetch(2'd0, 32'h8000_0014);
    fetch(2'd1, 32'h8000_0040);
    fetch(2'd0, 32'h8000_0040);
    fetch(2'd0, 32'h8000_0044);

    // Fill with attaboys while the FE stalls, drop a fifth, then drain in order.
    fe_cmd_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      attaboy_v_i = 1'b1; attaboy_pc_i = V'(32'h1000 + i * 4); attaboy_meta_i = BMF'(i + 1);
      step();
    end
    idle();
    for (int i = 0; i < 5; i++) step();

    // All three requests at once: only the redirect is taken.
    redirect_v_i = 1'b1; redirect_pc_i = 32'h0000_0300; redirect_meta_i = BMF'($urandom);
    fence_v_i = 1'b1; fence_pc_i = 32'h0000_0500;
    attaboy_v_i = 1'b1; attaboy_pc_i = 32'h0000_0600;
    step();
    idle();
    step();

    // Retargeting while squashing: the old target is now stale.
    redirect_v_i = 1'b1; redirect_pc_i = 32'h0000_0200;
    step();
    redirect_pc_i = 32'h0000_0100;
    step();
    idle();
    fetch(2'd0, 32'h0000_0200);
    fetch(2'd0, 32'h0000_0100);

    // Reset mid-operation with commands queued and a squash in progress.
    fe_cmd_ready_i = 1'b0;
    redirect_v_i = 1'b1; redirect_pc_i = 32'h0000_0700;
    step();
    redirect_v_i = 1'b0; attaboy_v_i = 1'b1; attaboy_pc_i = 32'h0000_0800;
    step();
    step();
    idle();
    fe_queue_v_i = 1'b1; fe_queue_i = mk_entry(2'd0, 32'h0000_0900);
    reset_n_i = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_cmd_q.delete();
    m_occ = 0; m_squash = 1'b0; m_target = '0; m_att_drop = 0;
    @(posedge clk_i); #1;
    reset_n_i = 1'b1;
    idle();
    fetch(2'd0, 32'h0000_0904);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      redirect_v_i    = ($urandom_range(0, 11) == 0);
      redirect_pc_i   = pick_pc();
      redirect_meta_i = BMF'($urandom);
      fence_v_i       = ($urandom_range(0, 11) == 0);
      fence_pc_i      = pick_pc();
      attaboy_v_i     = ($urandom_range(0, 3) == 0);
      attaboy_pc_i    = V'($urandom);
      attaboy_meta_i  = BMF'($urandom);
      fe_queue_v_i    = ($urandom_range(0, 9) < 7);
      fe_queue_i      = mk_entry(($urandom_range(0, 9) == 0) ? 2'd1 : 2'd0, pick_pc());
      issue_ready_i   = ($urandom_range(0, 4) != 0);
      fe_cmd_ready_i  = ($urandom_range(0, 4) < 3);
      step();
    end

    // Drain within a fixed cycle budget.
    idle();
    for (int c = 0; c < 10; c++) step();
    check("cmd_queue_drained", 128'(exp_cmd_q.size()), 128'(0));
    check("issue_queue_drained", 128'(exp_iss_q.size()), 128'(0));
`ifdef BP_BE_FE_CMD_STATS_EN
    check("attaboy_drop_cnt", 128'(attaboy_drop_cnt_o), 128'(m_att_drop));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
